// File: rtl/alu32_pkg.sv
// alu32_pkg
// Shared constants and helpers for the ALU32 family. The XOR stream
// decryptor and its matching encryptor both import this package, so the
// keystream generator below must stay identical on both sides.
//   WIDTH         data/key width (only 32 is supported)
//   DEFAULT_SEED  reset key value; also substituted for a zero seed
//   DEFAULT_TAPS  Galois feedback polynomial
//   state_t       stream FSM encoding
//   lfsr_next     one step of the Galois LFSR
package alu32_pkg;

  localparam int          WIDTH        = 32;
  localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;
  localparam logic [31:0] DEFAULT_TAPS = 32'h04C1_1DB7;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Shift left; when the bit falling off the top is set, fold the
  // polynomial back in. A nonzero key never maps to zero.
  function automatic logic [31:0] lfsr_next(input logic [31:0] k,
                                            input logic [31:0] taps);
    lfsr_next = {k[30:0], 1'b0} ^ (k[31] ? taps : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/xor_stream_decrypt32_if.sv
// xor_stream_decrypt32_if
// Word stream bundle for the XOR stream decryptor: an input side
// (in_valid/in_ready/In1) and an output side (out_valid/out_ready/cout1).
//   slave  : the decryptor's view (consumes In1, produces cout1)
//   master : the surrounding source/sink's view
interface xor_stream_decrypt32_if #(
  parameter int W = alu32_pkg::WIDTH
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] In1;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] cout1;

  modport slave (
    input  in_valid, In1, out_ready,
    output in_ready, out_valid, cout1
  );

  modport master (
    output in_valid, In1, out_ready,
    input  in_ready, out_valid, cout1
  );

endinterface

// File: rtl/xor_stream_decrypt32_lfsr.sv
// xor_keystream_lfsr32
// Keystream register for the stream decryptor. Holds the current key,
// reloads it from seed_in (substituting SEED for a zero seed so the LFSR
// can never lock up), and steps it once per accepted word.
//   clk, rst : clock, synchronous active-high reset (key <= SEED)
//   load     : load seed_in (wins over advance)
//   seed_in  : new key value
//   advance  : step the LFSR by one
//   key      : current keystream word
module xor_keystream_lfsr32 #(
  parameter logic [31:0] SEED = alu32_pkg::DEFAULT_SEED,
  parameter logic [31:0] TAPS = alu32_pkg::DEFAULT_TAPS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed_in,
  input  logic        advance,
  output logic [31:0] key
);

  import alu32_pkg::*;

  always_ff @(posedge clk) begin
    if (rst) begin
      key <= SEED;
    end else if (load) begin
      key <= (seed_in == 32'h0000_0000) ? SEED : seed_in;
    end else if (advance) begin
      key <= lfsr_next(key, TAPS);
    end
  end

endmodule

// File: rtl/xor_stream_decrypt32.sv
// xor_stream_decrypt32
// Recovers plaintext from a stream produced upstream as data ^ keystream.
// Each accepted word is XORed with the current key into a one-entry output
// register and the keystream steps. Valid/ready on both sides; full rate
// when the sink keeps out_ready high.
//   clk, rst   : clock, synchronous active-high reset
//   seed_load  : load seed_in as the key, clear word_cnt, enter ACTIVE
//   seed_in    : new key value (zero selects SEED)
//   stream     : in_valid/in_ready/In1 and out_valid/out_ready/cout1
//   word_cnt   : words accepted since the last reset or seed load (wraps)
//   active     : FSM is in ACTIVE
module xor_stream_decrypt32 #(
  parameter int          WIDTH = 32,
  parameter logic [31:0] SEED  = alu32_pkg::DEFAULT_SEED,
  parameter logic [31:0] TAPS  = alu32_pkg::DEFAULT_TAPS,
  parameter int          CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        seed_load,
  input  logic [WIDTH-1:0]            seed_in,
  xor_stream_decrypt32_if.slave       stream,
  output logic [CNT_W-1:0]            word_cnt,
  output logic                        active
);

  import alu32_pkg::*;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   key;
  logic [WIDTH-1:0]   cout_q;
  logic               out_valid_q;
  logic               in_ready_c;
  logic               accept;
  logic               consume;

  xor_keystream_lfsr32 #(
    .SEED (SEED),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (seed_load),
    .seed_in (seed_in),
    .advance (accept),
    .key     (key)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The only way out of ACTIVE is reset; seed_load in ACTIVE just rekeys.
  // seed_load blocks acceptance so a word is never XORed with a key that
  // is being replaced in the same cycle.
  always_comb begin
    state_next = state;
    if (seed_load) begin
      state_next = ACTIVE;
    end
    active     = (state == ACTIVE);
    in_ready_c = active && !seed_load && (!out_valid_q || stream.out_ready);
    accept     = stream.in_valid && in_ready_c;
    consume    = out_valid_q && stream.out_ready;
  end

  // Accept takes priority over consume so a simultaneous handoff keeps
  // out_valid high; cout1 is left untouched when the word simply drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      cout_q      <= '0;
      word_cnt    <= '0;
    end else begin
      if (accept) begin
        cout_q      <= stream.In1 ^ key;
        out_valid_q <= 1'b1;
      end else if (consume) begin
        out_valid_q <= 1'b0;
      end
      if (seed_load) begin
        word_cnt <= '0;
      end else if (accept) begin
        word_cnt <= word_cnt + CNT_W'(1);
      end
    end
  end

  assign stream.in_ready  = in_ready_c;
  assign stream.out_valid = out_valid_q;
  assign stream.cout1     = cout_q;

endmodule

// File: tb/tb_xor_stream_decrypt32.sv
// tb_xor_stream_decrypt32
// Scoreboard bench for xor_stream_decrypt32. A second instance is chained
// behind the first for the round-trip scenario: XOR with the same keystream
// twice must give back the original words.
module tb_xor_stream_decrypt32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        seedLoad   = 1'b0;
  logic        seedLoad2  = 1'b0;
  logic [31:0] seedIn     = '0;
  logic [31:0] seedIn2    = '0;
  logic        tbInValid  = 1'b0;
  logic        tbOutReady = 1'b0;
  logic        rtMode     = 1'b0;
  logic [31:0] tbIn       = '0;
  logic [15:0] wordCnt, wordCnt2;
  logic        active, active2;

  xor_stream_decrypt32_if a ();
  xor_stream_decrypt32_if b ();

  assign a.in_valid  = tbInValid;
  assign a.In1       = tbIn;
  assign a.out_ready = rtMode ? b.in_ready : tbOutReady;
  assign b.in_valid  = a.out_valid;
  assign b.In1       = a.cout1;
  assign b.out_ready = 1'b1;

  xor_stream_decrypt32 dut (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seedLoad),
    .seed_in   (seedIn),
    .stream    (a.slave),
    .word_cnt  (wordCnt),
    .active    (active)
  );

  xor_stream_decrypt32 dut2 (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seedLoad2),
    .seed_in   (seedIn2),
    .stream    (b.slave),
    .word_cnt  (wordCnt2),
    .active    (active2)
  );

  int checks = 0;
  int errors = 0;

  // Reference state of the first instance.
  logic [31:0] mKey      = 32'h0000_0001;
  logic        mActive   = 1'b0;
  logic        mOutValid = 1'b0;
  logic [15:0] mCnt      = '0;
  logic [31:0] lastCout  = '0;
  logic [31:0] q[$];

  function automatic logic [31:0] modelStep(input logic [31:0] k);
    logic [31:0] r;
    r = k << 1;
    if (k[31]) r = r ^ 32'h04C1_1DB7;
    return r;
  endfunction

  // Forces reset for one cycle and resets the reference model to match.
  task automatic doReset();
    rst = 1'b1; tbInValid = 1'b0; tbOutReady = 1'b0;
    seedLoad = 1'b0; seedLoad2 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mKey = 32'h0000_0001; mActive = 1'b0; mOutValid = 1'b0; mCnt = '0;
    q.delete();
  endtask

  // One clock of stimulus on the first instance, checked against the model.
  task automatic step(input logic inV, input logic [31:0] inD, input logic outR,
                      input logic seedL, input logic [31:0] seedD);
    logic        expReady, accept, consume;
    logic [31:0] expOut;
    tbInValid = inV; tbIn = inD; tbOutReady = outR;
    seedLoad = seedL; seedIn = seedD;
    #1;
    expReady = mActive && !seedL && (!mOutValid || outR);
    checks++;
    if (a.in_ready !== expReady) begin
      errors++;
      $display("[TB] FAIL in_ready: got %b expected %b", a.in_ready, expReady);
    end
    checks++;
    if (a.out_valid !== mOutValid) begin
      errors++;
      $display("[TB] FAIL out_valid: got %b expected %b", a.out_valid, mOutValid);
    end
    if (mOutValid) begin
      expOut = (q.size() > 0) ? q[0] : 32'hxxxx_xxxx;
      checks++;
      if (q.size() == 0 || a.cout1 !== expOut) begin
        errors++;
        $display("[TB] FAIL cout1: got %h expected %h", a.cout1, expOut);
      end
    end
    consume = mOutValid && outR;
    accept  = inV && expReady;
    if (consume) begin
      lastCout = a.cout1;
      if (q.size() > 0) void'(q.pop_front());
    end
    if (accept) begin
      q.push_back(inD ^ mKey);
      mKey = modelStep(mKey);
      mCnt = mCnt + 16'd1;
    end
    if (seedL) begin
      mKey = (seedD == 32'h0) ? 32'h0000_0001 : seedD;
      mCnt = '0;
      mActive = 1'b1;
    end
    mOutValid = accept ? 1'b1 : (consume ? 1'b0 : mOutValid);
    @(negedge clk);
    tbInValid = 1'b0; seedLoad = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    #1;
    checks++;
    if (a.out_valid !== 1'b0 || active !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got out_valid=%b active=%b expected 0 0", a.out_valid, active);
    end
    checks++;
    if (a.cout1 !== 32'h0 || wordCnt !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_values: got cout1=%h word_cnt=%0d expected 0 0", a.cout1, wordCnt);
    end
    checks++;
    if (a.in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b expected 0", a.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    doReset();
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0001);
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    checks++;
    if (a.cout1 !== 32'hDEAD_BEEE) begin
      errors++;
      $display("[TB] FAIL basic_word0: got %h expected deadbeee", a.cout1);
    end
    step(1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (lastCout !== 32'h0000_0002 || wordCnt !== 16'd2) begin
      errors++;
      $display("[TB] FAIL basic_word1: got %h cnt=%0d expected 00000002 cnt=2", lastCout, wordCnt);
    end
  endtask

  task automatic test_feedback();
    doReset();
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0000);
    step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
    checks++;
    if (a.cout1 !== 32'h7FFF_FFFF) begin
      errors++;
      $display("[TB] FAIL feedback_word0: got %h expected 7fffffff", a.cout1);
    end
    step(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (lastCout !== 32'h04C1_1DB7) begin
      errors++;
      $display("[TB] FAIL feedback_word1: got %h expected 04c11db7", lastCout);
    end
  endtask

  task automatic test_backpressure();
    doReset();
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h1234_5678);
    step(1'b1, 32'h1111_2222, 1'b1, 1'b0, 32'h0);
    repeat (5) step(1'b1, 32'h3333_4444, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h3333_4444, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (lastCout !== (32'h3333_4444 ^ modelStep(32'h1234_5678)) || wordCnt !== 16'd2) begin
      errors++;
      $display("[TB] FAIL backpressure_word1: got %h cnt=%0d expected %h cnt=2",
               lastCout, wordCnt, 32'h3333_4444 ^ modelStep(32'h1234_5678));
    end
  endtask

  task automatic test_idle_zero_seed();
    doReset();
    repeat (3) step(1'b1, 32'hAAAA_5555, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0000);
    step(1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0);
    checks++;
    if (a.cout1 !== 32'hCAFE_F00C) begin
      errors++;
      $display("[TB] FAIL zero_seed: got %h expected cafef00c", a.cout1);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_seed_priority_and_reset();
    doReset();
    step(1'b1, 32'h1111_1111, 1'b1, 1'b1, 32'hABCD_0000);
    checks++;
    if (wordCnt !== 16'd0 || a.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL seed_priority: got cnt=%0d out_valid=%b expected 0 0", wordCnt, a.out_valid);
    end
    step(1'b1, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0F0F_0F0F);
    step(1'b1, 32'h0000_FFFF, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'h7777_0000, 1'b0, 1'b0, 32'h0);
    checks++;
    if (a.out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pending_before_reset: got %b expected 1", a.out_valid);
    end
    doReset();
    #1;
    checks++;
    if (a.out_valid !== 1'b0 || active !== 1'b0 || wordCnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got out_valid=%b active=%b cnt=%0d expected 0 0 0",
               a.out_valid, active, wordCnt);
    end
    @(negedge clk);
  endtask

  task automatic test_round_trip();
    logic [31:0] rq[$];
    logic [31:0] exp;
    int sent, recvd, cycles;
    doReset();
    rtMode = 1'b1;
    seedLoad = 1'b1; seedIn = 32'h9E37_79B9;
    seedLoad2 = 1'b1; seedIn2 = 32'h9E37_79B9;
    @(negedge clk);
    seedLoad = 1'b0; seedLoad2 = 1'b0;
    sent = 0; recvd = 0; cycles = 0;
    while (recvd < 1000 && cycles < 5000) begin
      tbInValid = (sent < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
      tbIn = $urandom;
      #1;
      if (tbInValid && a.in_ready) begin
        rq.push_back(tbIn);
        sent++;
      end
      if (b.out_valid) begin
        exp = (rq.size() > 0) ? rq.pop_front() : 32'hxxxx_xxxx;
        checks++;
        if (b.cout1 !== exp) begin
          errors++;
          $display("[TB] FAIL round_trip word %0d: got %h expected %h", recvd, b.cout1, exp);
        end
        recvd++;
      end
      @(negedge clk);
      cycles++;
    end
    tbInValid = 1'b0;
    checks++;
    if (recvd != 1000) begin
      errors++;
      $display("[TB] FAIL round_trip_timeout: got %0d words expected 1000", recvd);
    end
    checks++;
    if (wordCnt !== 16'd1000 || wordCnt2 !== 16'd1000) begin
      errors++;
      $display("[TB] FAIL round_trip_count: got %0d/%0d expected 1000/1000", wordCnt, wordCnt2);
    end
    rtMode = 1'b0;
    doReset();
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_basic();
    test_feedback();
    test_backpressure();
    test_idle_zero_seed();
    test_seed_priority_and_reset();
    test_round_trip();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
